// File: rtl/line_fifo_bank_pkg.sv
// Shared sizing helpers, pointer wrap function and lane slice macro for the
// multi-channel line buffer.
`ifndef LINE_FIFO_BANK_LANE
`define LINE_FIFO_BANK_LANE
`define LFB_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package line_fifo_bank_pkg;

    function automatic int calc_ptr_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
        if (ptr == (depth - 32'd1)) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_ram_bank.sv
// Simple-dual-port block RAM holding all lanes side by side, with a
// registered, enabled read port that doubles as the output register.
module fifo_ram_bank #(
    parameter int WIDTH  = 256,
    parameter int DEPTH  = 4608,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_zero,
    output logic [WIDTH-1:0]  rd_data
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port output register; rd_zero blanks it on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else if (rd_zero) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/line_fifo_bank.sv
// Multi-lane line buffer with shared pointers, occupancy status, sticky error
// flags and a read-pointer mark/rewind for replaying a stored tile row.
module line_fifo_bank
    import line_fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 4608,
    parameter int NUM_CH       = 16,
    parameter int ZERO_ON_IDLE = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rd_clr,
    input  logic                            wr_clr,
    input  logic                            rd_en,
    input  logic                            rd_inc,
    input  logic                            wr_en,
    input  logic                            wr_inc,
    input  logic                            rd_mark,
    input  logic                            rd_rewind,
    input  logic                            rd_release,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    data_in,
    output logic [NUM_CH*DATA_WIDTH-1:0]    data_out,
    output logic                            data_valid,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int PTR_W = calc_ptr_w(DEPTH);
    localparam int CNT_W = calc_cnt_w(DEPTH);
    localparam int BUS_W = NUM_CH * DATA_WIDTH;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic ZERO_IDLE = (ZERO_ON_IDLE != 0);

    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, mark_ptr_r;
    logic             mark_act_r;
    logic [CNT_W-1:0] cnt_avail_r, cnt_held_r;
    logic             data_valid_r, full_r, empty_r, overflow_r, underflow_r;

    logic [PTR_W-1:0] rd_ptr_d, wr_ptr_d, mark_ptr_d;
    logic             mark_act_d;
    logic [CNT_W-1:0] cnt_avail_d, cnt_held_d;
    logic             overflow_d, underflow_d;

    logic             rd_blk_s, wr_room_s, wr_ok_s, rd_ok_s, rd_under_s;
    logic             wr_step_s, rd_step_s;
    logic [CNT_W-1:0] avail_wr_s, held_wr_s;

    // Accept decisions, all based on start-of-cycle counts.
    always_comb begin
        rd_blk_s   = rd_clr || rd_rewind;
        wr_room_s  = (cnt_held_r < CNT_FULL);
        wr_ok_s    = wr_en && !wr_clr && wr_room_s;
        rd_ok_s    = rd_en && !rd_blk_s && (cnt_avail_r != '0);
        rd_under_s = rd_en && !rd_blk_s && (cnt_avail_r == '0);
        wr_step_s  = wr_ok_s && wr_inc;
        rd_step_s  = rd_ok_s && rd_inc;
        avail_wr_s = cnt_avail_r + CNT_W'(wr_step_s);
        held_wr_s  = cnt_held_r + CNT_W'(wr_step_s);
    end

    // Next-state: normal pointer/count motion, then read-side events by
    // priority, then the write-side clear.
    always_comb begin
        wr_ptr_d    = wr_step_s ? PTR_W'(wrap_inc(32'(wr_ptr_r), 32'(DEPTH))) : wr_ptr_r;
        rd_ptr_d    = rd_step_s ? PTR_W'(wrap_inc(32'(rd_ptr_r), 32'(DEPTH))) : rd_ptr_r;
        mark_ptr_d  = mark_ptr_r;
        mark_act_d  = mark_act_r;
        cnt_avail_d = avail_wr_s - CNT_W'(rd_step_s);
        cnt_held_d  = held_wr_s - CNT_W'(rd_step_s && !mark_act_r);
        overflow_d  = overflow_r || (wr_en && !wr_clr && !wr_room_s);
        underflow_d = underflow_r || rd_under_s;

        if (rd_clr) begin
            rd_ptr_d    = '0;
            mark_act_d  = 1'b0;
            cnt_avail_d = CNT_W'(wr_ptr_d);
            cnt_held_d  = CNT_W'(wr_ptr_d);
            underflow_d = 1'b0;
        end else if (rd_rewind) begin
            if (mark_act_r) begin
                rd_ptr_d    = mark_ptr_r;
                cnt_avail_d = held_wr_s;
                cnt_held_d  = held_wr_s;
            end else begin
                rd_ptr_d    = rd_ptr_r;
            end
        end else if (rd_release) begin
            mark_act_d = 1'b0;
            cnt_held_d = cnt_avail_d;
        end else if (rd_mark) begin
            mark_ptr_d = rd_ptr_r;
            mark_act_d = 1'b1;
            cnt_held_d = avail_wr_s;
        end else begin
            mark_act_d = mark_act_r;
        end

        if (wr_clr) begin
            wr_ptr_d    = '0;
            cnt_avail_d = '0;
            cnt_held_d  = '0;
            overflow_d  = 1'b0;
        end else begin
            wr_ptr_d    = wr_ptr_d;
        end
    end

    // Control state register; status flags are registered from next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            mark_ptr_r   <= '0;
            mark_act_r   <= 1'b0;
            cnt_avail_r  <= '0;
            cnt_held_r   <= '0;
            data_valid_r <= 1'b0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            rd_ptr_r     <= rd_ptr_d;
            wr_ptr_r     <= wr_ptr_d;
            mark_ptr_r   <= mark_ptr_d;
            mark_act_r   <= mark_act_d;
            cnt_avail_r  <= cnt_avail_d;
            cnt_held_r   <= cnt_held_d;
            data_valid_r <= rd_ok_s;
            full_r       <= (cnt_held_d == CNT_FULL);
            empty_r      <= (cnt_avail_d == '0);
            overflow_r   <= overflow_d;
            underflow_r  <= underflow_d;
        end
    end

    fifo_ram_bank #(
        .WIDTH  (BUS_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data_in),
        .rd_en   (rd_ok_s),
        .rd_addr (rd_ptr_r),
        .rd_zero (ZERO_IDLE),
        .rd_data (data_out)
    );

    assign data_valid = data_valid_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign count      = cnt_avail_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_line_fifo_bank.sv
// Directed bench for line_fifo_bank (DEPTH=6, 2 lanes of 8 bits).
module tb_line_fifo_bank;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int DP = 6;

    logic          clk = 1'b0;
    logic          rst_n, rd_clr, wr_clr, rd_en, rd_inc, wr_en, wr_inc;
    logic          rd_mark, rd_rewind, rd_release;
    logic [15:0]   data_in, data_out;
    logic          data_valid, full, empty, overflow, underflow;
    logic [2:0]    count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    line_fifo_bank #(
        .DATA_WIDTH(DW), .DEPTH(DP), .NUM_CH(NC), .ZERO_ON_IDLE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_clr(rd_clr), .wr_clr(wr_clr),
        .rd_en(rd_en), .rd_inc(rd_inc), .wr_en(wr_en), .wr_inc(wr_inc),
        .rd_mark(rd_mark), .rd_rewind(rd_rewind), .rd_release(rd_release),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // lane 0 = v, lane 1 = ~v
    function automatic logic [15:0] wd(input logic [7:0] v);
        return {~v, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] v);
        wr_en = 1'b1; wr_inc = 1'b1; data_in = wd(v);
        tick();
        wr_en = 1'b0; wr_inc = 1'b0;
    endtask

    task automatic do_read();
        rd_en = 1'b1; rd_inc = 1'b1;
        tick();
        rd_en = 1'b0; rd_inc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_clr = 1'b0; wr_clr = 1'b0; rd_en = 1'b0; rd_inc = 1'b0;
        wr_en = 1'b0; wr_inc = 1'b0; rd_mark = 1'b0; rd_rewind = 1'b0;
        rd_release = 1'b0; data_in = 16'h0;
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill to DEPTH, then one dropped write
        for (int k = 1; k <= 6; k++) begin
            do_write(8'(k));
            chk("fill_count", 32'(count), 32'(k));
        end
        chk("fill_full", 32'(full), 32'd1);
        do_write(8'd7);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd6);

        // read two, write two across the wrap, drain in order
        do_read();
        chk("rd1_data", 32'(data_out), 32'(wd(8'd1)));
        chk("rd1_valid", 32'(data_valid), 32'd1);
        do_read();
        chk("rd2_data", 32'(data_out), 32'(wd(8'd2)));
        chk("rd2_count", 32'(count), 32'd4);
        chk("rd2_full", 32'(full), 32'd0);
        do_write(8'd7);
        do_write(8'd8);
        chk("wrap_count", 32'(count), 32'd6);
        chk("wrap_full", 32'(full), 32'd1);
        for (int k = 3; k <= 8; k++) begin
            do_read();
            chk("drain_data", 32'(data_out), 32'(wd(8'(k))));
            chk("drain_valid", 32'(data_valid), 32'd1);
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        tick();
        chk("idle_dout", 32'(data_out), 32'd0);
        chk("idle_valid", 32'(data_valid), 32'd0);

        // read while empty
        do_read();
        chk("udf_valid", 32'(data_valid), 32'd0);
        chk("udf_dout", 32'(data_out), 32'd0);
        chk("udf_flag", 32'(underflow), 32'd1);

        // both clears together
        rd_clr = 1'b1; wr_clr = 1'b1;
        tick();
        rd_clr = 1'b0; wr_clr = 1'b0;
        chk("clr_flags", 32'({overflow, underflow}), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);

        // mark, read four, blocked write, rewind with rd_en, reread
        for (int k = 11; k <= 16; k++) do_write(8'(k));
        rd_mark = 1'b1;
        tick();
        rd_mark = 1'b0;
        for (int k = 11; k <= 14; k++) begin
            do_read();
            chk("mk_data", 32'(data_out), 32'(wd(8'(k))));
        end
        chk("mk_count", 32'(count), 32'd2);
        chk("mk_full", 32'(full), 32'd1);
        do_write(8'd20);
        chk("mk_ovf", 32'(overflow), 32'd1);
        chk("mk_ovf_count", 32'(count), 32'd2);
        rd_rewind = 1'b1; rd_en = 1'b1; rd_inc = 1'b1;
        tick();
        rd_rewind = 1'b0; rd_en = 1'b0; rd_inc = 1'b0;
        chk("rew_valid", 32'(data_valid), 32'd0);
        chk("rew_dout", 32'(data_out), 32'd0);
        chk("rew_count", 32'(count), 32'd6);
        for (int k = 11; k <= 14; k++) begin
            do_read();
            chk("reread_data", 32'(data_out), 32'(wd(8'(k))));
        end

        // peek three times
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b1; rd_inc = 1'b0;
            tick();
            rd_en = 1'b0;
            chk("peek_data", 32'(data_out), 32'(wd(8'd15)));
            chk("peek_count", 32'(count), 32'd2);
        end

        // release frees the marked space
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        chk("rel_full", 32'(full), 32'd0);
        do_write(8'd21);
        chk("rel_count", 32'(count), 32'd3);

        // asynchronous reset in the middle of a read burst
        rd_en = 1'b1; rd_inc = 1'b1;
        tick();
        chk("burst_data", 32'(data_out), 32'(wd(8'd15)));
        #2;
        rst_n = 1'b0;
        rd_en = 1'b0; rd_inc = 1'b0;
        #1;
        chk("arst_dout", 32'(data_out), 32'd0);
        chk("arst_valid", 32'(data_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(8'h33);
        chk("post_count", 32'(count), 32'd1);
        do_read();
        chk("post_addr0", 32'(data_out), 32'(wd(8'h33)));
        chk("post_valid", 32'(data_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
